// File: rtl/crc_pkg.sv
// crc_pkg: shared definitions for the CRC-8 frame controller.
//   - state_t : frame controller FSM states
//   - mode_t  : frame mode latched at start (generate / check)
//   - default CRC-8 polynomial, initial value and output XOR
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_GEN   = 1'b0,
    MODE_CHECK = 1'b1
  } mode_t;

  localparam logic [7:0]  CRC8_POLY_DEF   = 8'h07;
  localparam logic [7:0]  CRC8_INIT_DEF   = 8'h00;
  localparam logic [7:0]  CRC8_XOROUT_DEF = 8'h00;
  localparam logic [15:0] BYTE_CNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/crc8_byte.sv
// crc8_byte: combinational one-byte CRC-8 update, MSB-first, non-reflected.
//   crc      in  8  current CRC register
//   data     in  8  byte to fold in
//   crc_next out 8  CRC register after folding data
module crc8_byte
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEF
) (
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  logic [7:0] c;

  always_comb begin
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: sequences a CRC-8 computation over a byte-stream frame.
//   clk, rst             clock, synchronous active-high reset
//   start, check_en      begin a frame (IDLE only); mode 0=generate 1=check
//   abort                drop current frame, back to IDLE, no result
//   s_valid/s_ready      byte handshake; s_data byte, s_last final byte
//   res_valid/res_ready  result handshake
//   res_crc              CRC register ^ XOROUT
//   res_ok               check mode: received CRC matched; generate mode: 1
//   byte_cnt             payload bytes folded this frame (saturating)
//   busy                 controller not in IDLE
module crc_frame_ctrl
  import crc_pkg::*;
#(
  parameter logic [7:0]  POLY     = CRC8_POLY_DEF,
  parameter logic [7:0]  INIT     = CRC8_INIT_DEF,
  parameter logic [7:0]  XOROUT   = CRC8_XOROUT_DEF,
  parameter int unsigned BYTE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        check_en,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_crc,
  output logic        res_ok,
  output logic [15:0] byte_cnt,
  output logic        busy
);

  localparam int unsigned GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (BYTE_GAP > 0) ? GW'(BYTE_GAP - 1) : '0;

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [7:0]    crc_q, crc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ok_q, ok_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          s_ready_q, s_ready_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;

  logic [7:0]    crc_fold;
  logic          accept;

  crc8_byte #(.POLY(POLY)) u_crc8 (
    .crc      (crc_q),
    .data     (s_data),
    .crc_next (crc_fold)
  );

  // s_ready_q is high exactly while in RUN, so accept needs no
  // combinational path from s_valid back to s_ready.
  assign accept = s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          crc_d   = INIT;
          cnt_d   = '0;
          mode_d  = mode_t'(check_en);
          gap_d   = '0;
          ok_d    = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (mode_q == MODE_CHECK && s_last) begin
            // Trailing byte is the received CRC: compare, do not fold or count.
            ok_d = ((crc_q ^ XOROUT) == s_data);
          end else begin
            crc_d = crc_fold;
            if (cnt_q != BYTE_CNT_MAX) begin
              cnt_d = cnt_q + 16'd1;
            end
            if (s_last) begin
              ok_d = 1'b1;
            end
          end

          if (s_last) begin
            state_d = ST_DONE;
          end else if (BYTE_GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      ST_DONE: begin
        if (abort || res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Handshake/status outputs are registered from the next state.
    s_ready_d   = (state_d == ST_RUN);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_GEN;
      crc_q       <= INIT;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
      gap_q       <= '0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      ok_q        <= ok_d;
      gap_q       <= gap_d;
      s_ready_q   <= s_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign res_valid = res_valid_q;
  assign res_crc   = crc_q ^ XOROUT;
  assign res_ok    = ok_q;
  assign byte_cnt  = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl: a vector table of whole frames,
// randomized frames checked against a bit-serial CRC-8 reference model, and
// hand-written sequences for abort, reset, result hold and byte pacing.
`timescale 1ns/1ps
module tb_crc_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, check_en, abort, s_valid, s_last, res_ready;
  logic [7:0] s_data;

  logic        s_ready0, res_valid0, res_ok0, busy0;
  logic [7:0]  res_crc0;
  logic [15:0] byte_cnt0;
  logic        s_ready3, res_valid3, res_ok3, busy3;
  logic [7:0]  res_crc3;
  logic [15:0] byte_cnt3;

  crc_frame_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start), .check_en(check_en), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid0), .res_ready(res_ready), .res_crc(res_crc0),
    .res_ok(res_ok0), .byte_cnt(byte_cnt0), .busy(busy0)
  );

  crc_frame_ctrl #(.BYTE_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .check_en(check_en), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid3), .res_ready(res_ready), .res_crc(res_crc3),
    .res_ok(res_ok3), .byte_cnt(byte_cnt3), .busy(busy3)
  );

  // Selects which instance the checks look at (0: BYTE_GAP=0, 1: BYTE_GAP=3).
  bit          sel = 1'b0;
  logic        rdy, rv, rok, rbusy;
  logic [7:0]  rcrc;
  logic [15:0] rcnt;

  always_comb begin
    rdy   = sel ? s_ready3   : s_ready0;
    rv    = sel ? res_valid3 : res_valid0;
    rok   = sel ? res_ok3    : res_ok0;
    rbusy = sel ? busy3      : busy0;
    rcrc  = sel ? res_crc3   : res_crc0;
    rcnt  = sel ? byte_cnt3  : byte_cnt0;
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fb [64];
  int         acc_cyc [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: polynomial division one message bit at a time, MSB first.
  function automatic logic [7:0] model_crc(input int n);
    logic [7:0] c;
    logic       fbk;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fbk = c[7] ^ fb[i][b];
        c = {c[6:0], 1'b0};
        if (fbk) c = c ^ 8'h07;
      end
    end
    return c ^ 8'h00;
  endfunction

  task automatic check_reset_vals(input string name);
    chk({name, ".s_ready"},   rdy,   0);
    chk({name, ".res_valid"}, rv,    0);
    chk({name, ".res_crc"},   rcrc,  8'h00);
    chk({name, ".res_ok"},    rok,   0);
    chk({name, ".byte_cnt"},  rcnt,  0);
    chk({name, ".busy"},      rbusy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; check_en = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic begin_frame(input bit mode);
    start = 1'b1; check_en = mode;
    @(negedge clk);
    start = 1'b0; check_en = 1'b0;
    chk("start.busy", rbusy, 1);
    chk("start.s_ready", rdy, 1);
  endtask

  // Offers fb[0..n-1] with s_valid held high; start is pulsed once while
  // waiting to offer byte start_at.
  task automatic send(input int n, input bit mark_last, input int start_at);
    for (int i = 0; i < n; i++) begin
      int w;
      s_valid = 1'b1; s_data = fb[i]; s_last = mark_last && (i == n - 1);
      if (i == start_at) start = 1'b1;
      w = 0;
      while (!rdy && w < 50) begin
        @(negedge clk);
        start = 1'b0;
        w++;
      end
      if (w >= 50) chk("accept_timeout", rdy, 1);
      acc_cyc[i] = cyc;
      @(negedge clk);
      start = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic take_result(input string name, input logic [7:0] ec, input bit eok,
                             input int ecnt, input int hold);
    chk({name, ".res_valid"}, rv,   1);
    chk({name, ".res_crc"},   rcrc, ec);
    chk({name, ".res_ok"},    rok,  eok);
    chk({name, ".byte_cnt"},  rcnt, ecnt);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, ".hold_valid"}, rv,   1);
      chk({name, ".hold_crc"},   rcrc, ec);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, ".idle_busy"},  rbusy, 0);
    chk({name, ".idle_valid"}, rv,    0);
  endtask

  typedef struct {
    bit          mode;
    int          n;
    logic [63:0] bytes;
    logic [7:0]  ec;
    bit          eok;
    int          ecnt;
    string       name;
  } vec_t;

  vec_t tbl [8];

  task automatic random_frames(input int count, input string tag);
    for (int r = 0; r < count; r++) begin
      bit         mode;
      int         n, p;
      logic [7:0] exp;
      bit         eok;
      mode = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) fb[j] = 8'($urandom);
      if (mode) begin
        p = n - 1;
        exp = model_crc(p);
        if ($urandom_range(0, 1) == 1) fb[p] = exp;
        eok = (fb[p] == exp);
      end else begin
        p = n;
        exp = model_crc(p);
        eok = 1'b1;
      end
      begin_frame(mode);
      send(n, 1'b1, -1);
      take_result(tag, exp, eok, p, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 2, 64'h0, 8'h00, 1'b0, 0, ""};
    tbl[0] = '{1'b0, 4, 64'h04030201,   8'hE3, 1'b1, 4, "gen_01020304"};
    tbl[1] = '{1'b1, 5, 64'hE304030201, 8'hE3, 1'b1, 4, "chk_good_E3"};
    tbl[2] = '{1'b1, 5, 64'hE204030201, 8'hE3, 1'b0, 4, "chk_bad_E2"};
    tbl[3] = '{1'b0, 1, 64'h01,         8'h07, 1'b1, 1, "gen_single_01"};
    tbl[4] = '{1'b1, 1, 64'h00,         8'h00, 1'b1, 0, "chk_empty_00"};
    tbl[5] = '{1'b1, 1, 64'h5A,         8'h00, 1'b0, 0, "chk_empty_bad"};
    tbl[6] = '{1'b0, 1, 64'hFF,         8'hF3, 1'b1, 1, "gen_single_FF"};
    tbl[7] = '{1'b1, 2, 64'h0701,       8'h07, 1'b1, 1, "chk_01_07"};

    // ---------------- BYTE_GAP = 0 instance ----------------
    sel = 1'b0;
    do_reset();
    check_reset_vals("reset0");

    for (int t = 0; t < 8; t++) begin
      logic [63:0] bv;
      bv = tbl[t].bytes;
      for (int j = 0; j < tbl[t].n; j++) fb[j] = bv[8*j +: 8];
      begin_frame(tbl[t].mode);
      send(tbl[t].n, 1'b1, -1);
      take_result(tbl[t].name, tbl[t].ec, tbl[t].eok, tbl[t].ecnt, 0);
    end

    random_frames(30, "rand0");

    // abort after two bytes, with a last byte offered in the abort cycle
    fb[0] = 8'h01; fb[1] = 8'h02;
    begin_frame(1'b0);
    send(2, 1'b0, -1);
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1; abort = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; abort = 1'b0;
    chk("abort.busy", rbusy, 0);
    chk("abort.res_valid", rv, 0);
    chk("abort.s_ready", rdy, 0);
    repeat (3) @(negedge clk);
    chk("abort.no_result", rv, 0);
    fb[0] = 8'h01;
    begin_frame(1'b0);
    send(1, 1'b1, -1);
    take_result("after_abort", 8'h07, 1'b1, 1, 0);

    // result held with res_ready low; start ignored in DONE and on the handshake cycle
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
    begin_frame(1'b0);
    send(4, 1'b1, -1);
    for (int k = 0; k < 5; k++) begin
      chk("hold.res_valid", rv, 1);
      chk("hold.res_crc", rcrc, 8'hE3);
      chk("hold.byte_cnt", rcnt, 4);
      chk("hold.res_ok", rok, 1);
      start = (k == 2);
      @(negedge clk);
      start = 1'b0;
    end
    chk("hold.still_valid", rv, 1);
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("handshake.busy", rbusy, 0);
    chk("handshake.res_valid", rv, 0);
    @(negedge clk);
    start = 1'b0;
    chk("restart.busy", rbusy, 1);
    chk("restart.s_ready", rdy, 1);
    fb[0] = 8'h01;
    send(1, 1'b1, -1);
    take_result("restart", 8'h07, 1'b1, 1, 0);

    // reset in the middle of a frame
    fb[0] = 8'hAA; fb[1] = 8'hBB;
    begin_frame(1'b0);
    send(2, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid");
    rst = 1'b0;

    // reset while a good result is presented
    fb[0] = 8'h01;
    begin_frame(1'b0);
    send(1, 1'b1, -1);
    chk("pre_reset.res_ok", rok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_done");
    rst = 1'b0;
    @(negedge clk);

    // ---------------- BYTE_GAP = 3 instance ----------------
    sel = 1'b1;
    do_reset();
    check_reset_vals("reset3");
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
    begin_frame(1'b0);
    send(4, 1'b1, 2);
    for (int i = 1; i < 4; i++) chk("gap.accept_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    take_result("gap_01020304", 8'hE3, 1'b1, 4, 0);

    random_frames(10, "rand3");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
